// File: rtl/axil_mtimer.sv
// axil_mtimer: AXI4-Lite machine timer (free-running 64-bit MTIME, 64-bit MTIMECMP,
// level interrupt when MTIME >= MTIMECMP while enabled).
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   s_axil_aw*/w*/b*  write channel; AW and W are accepted independently and held
//   s_axil_ar*/r*     read channel; one outstanding read
//   irq               registered timer interrupt
//
// Register map (addr[4:2]):
//   0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 EN); 5-7 SLVERR.
module axil_mtimer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4,
    parameter int PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic                  irq
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic                  en;
    logic [PW-1:0]         pcnt;
    logic [31:0]           shadow;

    logic                  aw_held;
    logic                  w_held;
    logic [2:0]            aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;

    logic                  commit;
    logic                  wr_mt_lo, wr_mt_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
    logic                  tick;
    logic                  unused_ok;

    // Bytes with a set strobe take new data, the rest keep the old value.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // A write commits only once both halves are held and the previous response is gone.
    assign commit    = aw_held && w_held && !s_axil_bvalid;
    assign wr_mt_lo  = commit && (aw_idx == 3'd0);
    assign wr_mt_hi  = commit && (aw_idx == 3'd1);
    assign wr_cmp_lo = commit && (aw_idx == 3'd2);
    assign wr_cmp_hi = commit && (aw_idx == 3'd3);
    assign wr_ctrl   = commit && (aw_idx == 3'd4);
    assign tick      = en && (pcnt == PMAX);

    assign s_axil_awready = !aw_held;
    assign s_axil_wready  = !w_held;
    assign s_axil_arready = !s_axil_rvalid;

    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime         <= '0;
            mtimecmp      <= '1;
            en            <= 1'b1;
            pcnt          <= '0;
            shadow        <= '0;
            irq           <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= 2'b00;
            s_axil_rvalid <= 1'b0;
            s_axil_rresp  <= 2'b00;
            s_axil_rdata  <= '0;
        end else begin
            // write channel capture / commit / response
            if (s_axil_awvalid && !aw_held) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axil_awaddr[4:2];
            end
            if (s_axil_wvalid && !w_held) begin
                w_held <= 1'b1;
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end
            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= (aw_idx > 3'd4) ? 2'b10 : 2'b00;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end

            // MTIME: a write overrides the increment and restarts the prescaler;
            // unwritten bytes keep the pre-increment value.
            if (wr_mt_lo || wr_mt_hi) begin
                mtime <= {wr_mt_hi ? merge(mtime[63:32], w_data, w_strb) : mtime[63:32],
                          wr_mt_lo ? merge(mtime[31:0],  w_data, w_strb) : mtime[31:0]};
                pcnt  <= '0;
            end else if (en) begin
                if (tick) begin
                    pcnt  <= '0;
                    mtime <= mtime + 64'd1;
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
            end

            if (wr_cmp_lo) mtimecmp[31:0]  <= merge(mtimecmp[31:0],  w_data, w_strb);
            if (wr_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], w_data, w_strb);
            if (wr_ctrl && w_strb[0]) en <= w_data[0];

            irq <= en && (mtime >= mtimecmp);

            // read channel; reading MTIME_LO snapshots the upper half for an atomic 64-bit read
            if (s_axil_arvalid && !s_axil_rvalid) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rresp  <= 2'b00;
                case (s_axil_araddr[4:2])
                    3'd0: begin
                        s_axil_rdata <= mtime[31:0];
                        shadow       <= mtime[63:32];
                    end
                    3'd1:    s_axil_rdata <= shadow;
                    3'd2:    s_axil_rdata <= mtimecmp[31:0];
                    3'd3:    s_axil_rdata <= mtimecmp[63:32];
                    3'd4:    s_axil_rdata <= {31'd0, en};
                    default: begin
                        s_axil_rdata <= '0;
                        s_axil_rresp <= 2'b10;
                    end
                endcase
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axil_mtimer.sv
// tb_axil_mtimer: randomized + directed bench for axil_mtimer (PRESCALE=1).
// Stimulus drives on the falling edge; a monitor keeps an arithmetic timer model
// (MTIME = base + elapsed edges while enabled) and checks responses from queues.
module tb_axil_mtimer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axil_awaddr = '0;
    logic [2:0]  s_axil_awprot = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [7:0]  s_axil_araddr = '0;
    logic [2:0]  s_axil_arprot = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    axil_mtimer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .STRB_WIDTH(4), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL timeout %s got no handshake expected one", nm);
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [7:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
    typedef struct { logic [31:0] d; logic [1:0] r; } rd_t;
    wr_t        wq[$];
    rd_t        rq[$];
    logic [1:0] bq[$];

    logic [63:0] m_base;
    longint      m_edge;
    bit          m_en;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    longint      edge_n = 0;

    // MTIME value as it stands after clock edge x
    function automatic logic [63:0] mt(input longint x);
        return m_en ? m_base + 64'(x - m_edge) : m_base;
    endfunction

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    initial begin : monitor
        bit         bv_prev;
        bit         started;
        bit         s_rst;
        bit         s_ar;
        logic [7:0] s_araddr;
        logic [63:0] pre;
        rd_t        e;
        wr_t        w;
        bv_prev = 0; started = 0; s_rst = 1; s_ar = 0; s_araddr = '0;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (s_rst) begin
                started = 1;
                m_base = '0; m_edge = edge_n; m_en = 1; m_cmp = '1; m_shadow = '0;
                wq.delete(); rq.delete(); bq.delete();
                chk("rst_irq", irq, 0);
                chk("rst_awready", s_axil_awready, 1);
                chk("rst_wready", s_axil_wready, 1);
                chk("rst_arready", s_axil_arready, 1);
                chk("rst_bvalid", s_axil_bvalid, 0);
                chk("rst_rvalid", s_axil_rvalid, 0);
                chk("rst_rdata", s_axil_rdata, 0);
            end else if (started) begin
                pre = mt(edge_n - 1);
                chk("irq", irq, (m_en && pre >= m_cmp) ? 1 : 0);
                if (s_ar) begin
                    e.r = 2'b00;
                    case (s_araddr[4:2])
                        3'd0: begin e.d = pre[31:0]; m_shadow = pre[63:32]; end
                        3'd1: e.d = m_shadow;
                        3'd2: e.d = m_cmp[31:0];
                        3'd3: e.d = m_cmp[63:32];
                        3'd4: e.d = {31'd0, m_en};
                        default: begin e.d = '0; e.r = 2'b10; end
                    endcase
                    rq.push_back(e);
                    chk("rvalid_latency", s_axil_rvalid, 1);
                end
                if (s_axil_bvalid && !bv_prev) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_bvalid", 1, 0);
                    end else begin
                        w = wq.pop_front();
                        bq.push_back((w.a[4:2] > 3'd4) ? 2'b10 : 2'b00);
                        case (w.a[4:2])
                            3'd0: begin m_base = {pre[63:32], bytes_merge(pre[31:0], w.d, w.s)}; m_edge = edge_n; end
                            3'd1: begin m_base = {bytes_merge(pre[63:32], w.d, w.s), pre[31:0]}; m_edge = edge_n; end
                            3'd2: m_cmp[31:0]  = bytes_merge(m_cmp[31:0],  w.d, w.s);
                            3'd3: m_cmp[63:32] = bytes_merge(m_cmp[63:32], w.d, w.s);
                            3'd4: if (w.s[0]) begin
                                m_base = mt(edge_n); m_edge = edge_n; m_en = w.d[0];
                            end
                            default: ;
                        endcase
                    end
                end
            end
            bv_prev = s_axil_bvalid;
            @(negedge clk);
            #2;
            if (started && !rst) begin
                if (s_axil_rvalid && s_axil_rready) begin
                    if (rq.size() == 0) chk("unexpected_rvalid", 1, 0);
                    else begin
                        e = rq.pop_front();
                        chk("rdata", s_axil_rdata, e.d);
                        chk("rresp", s_axil_rresp, e.r);
                    end
                end
                if (s_axil_bvalid && s_axil_bready) begin
                    if (bq.size() == 0) chk("unexpected_bresp", 1, 0);
                    else chk("bresp", s_axil_bresp, bq.pop_front());
                end
            end
            s_rst    = rst;
            s_ar     = s_axil_arvalid && s_axil_arready;
            s_araddr = s_axil_araddr;
        end
    end

    // ---------------- stimulus tasks (called on a falling edge) ----------------
    task automatic send_aw(input logic [7:0] a);
        int n = 0;
        s_axil_awaddr = a; s_axil_awvalid = 1'b1;
        while (!s_axil_awready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) tmo("aw");
        @(negedge clk);
        s_axil_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
        while (!s_axil_wready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) tmo("w");
        @(negedge clk);
        s_axil_wvalid = 1'b0;
    endtask

    task automatic take_b(input int hold);
        int n = 0;
        while (!s_axil_bvalid && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) tmo("b");
        repeat (hold) @(negedge clk);
        s_axil_bready = 1'b1;
        @(negedge clk);
        s_axil_bready = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int gap, input int hold);
        wq.push_back('{a, d, s});
        fork
            send_aw(a);
            begin repeat (gap) @(negedge clk); send_w(d, s); end
        join
        // last handshake edge is behind us; the response must follow on the next edge
        @(negedge clk);
        chk("bvalid_latency", s_axil_bvalid, 1);
        take_b(hold);
    endtask

    task automatic send_ar(input logic [7:0] a);
        int n = 0;
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        while (!s_axil_arready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) tmo("ar");
        @(negedge clk);
        s_axil_arvalid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input int hold);
        int n = 0;
        send_ar(a);
        while (!s_axil_rvalid && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) tmo("r");
        repeat (hold) @(negedge clk);
        s_axil_rready = 1'b1;
        @(negedge clk);
        s_axil_rready = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin : stim
        int n;
        logic [31:0] r32;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset value of MTIMECMP_HI
        rd(8'h0C, 0);

        // irq rises when MTIME reaches MTIMECMP, falls when compare goes false
        wr(8'h10, 32'h0, 4'hF, 0, 0);
        wr(8'h08, 32'd10, 4'hF, 0, 0);
        wr(8'h0C, 32'h0, 4'hF, 0, 0);
        wr(8'h00, 32'h0, 4'hF, 0, 0);
        wr(8'h04, 32'h0, 4'hF, 0, 0);
        wr(8'h10, 32'h1, 4'hF, 0, 0);
        n = 0;
        while (!irq && n < 50) begin @(negedge clk); n++; end
        chk("irq_rise", irq, 1);
        wr(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 0);
        repeat (2) @(negedge clk);
        chk("irq_fall", irq, 0);

        // carry from MTIME_LO into MTIME_HI, atomic LO/HI read
        wr(8'h04, 32'h0, 4'hF, 0, 0);
        wr(8'h00, 32'hFFFF_FFFF, 4'hF, 1, 0);
        repeat (3) @(negedge clk);
        rd(8'h00, 0);
        rd(8'h04, 2);

        // split AW/W, delayed bready, second write stalls behind the response
        wq.push_back('{8'h08, 32'h0000_1234, 4'hF});
        s_axil_awaddr = 8'h08; s_axil_awvalid = 1'b1;
        @(negedge clk);
        s_axil_awvalid = 1'b0;
        repeat (2) @(negedge clk);
        send_w(32'h0000_1234, 4'hF);
        @(negedge clk);
        chk("split_bvalid", s_axil_bvalid, 1);
        wq.push_back('{8'h0C, 32'h0000_0000, 4'hF});
        fork
            send_aw(8'h0C);
            send_w(32'h0000_0000, 4'hF);
        join
        repeat (4) begin
            chk("b_hold", s_axil_bvalid, 1);
            chk("aw_stall", s_axil_awready, 0);
            @(negedge clk);
        end
        take_b(0);
        take_b(1);
        wr(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 0);

        // unmapped accesses
        rd(8'h14, 0);
        wr(8'h1C, 32'hDEAD_BEEF, 4'hF, 0, 0);
        rd(8'h08, 0);
        rd(8'h10, 0);

        // frozen timer, byte-lane write
        wr(8'h10, 32'h0, 4'hF, 0, 0);
        rd(8'h00, 0);
        repeat (100) @(negedge clk);
        rd(8'h00, 0);
        rd(8'h04, 0);
        wr(8'h00, 32'h5555_55AA, 4'b0001, 0, 0);
        rd(8'h00, 0);
        rd(8'h04, 0);
        wr(8'h10, 32'h1, 4'hF, 0, 0);

        // reset in the middle of an unaccepted read and a half-written write
        send_ar(8'h00);
        n = 0;
        while (!s_axil_rvalid && n < 50) begin @(negedge clk); n++; end
        send_aw(8'h08);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(8'h0C, 0);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            int op, ri, gap, hold;
            logic [2:0]  idx;
            logic [31:0] d;
            logic [3:0]  s;
            op   = $urandom_range(0, 2);
            ri   = $urandom_range(0, 9);
            idx  = (ri < 8) ? 3'(ri % 5) : 3'(5 + ri % 3);
            gap  = $urandom_range(0, 3);
            hold = $urandom_range(0, 3);
            r32  = $urandom();
            s    = 4'($urandom_range(0, 15));
            case (idx)
                3'd2:    d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3000)) : r32;
                3'd3:    d = ($urandom_range(0, 3) == 0) ? r32 : 32'h0;
                3'd4:    d = {r32[31:1], ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0};
                default: d = r32;
            endcase
            if (op == 0) wr({3'b000, idx, 2'b00}, d, s, gap, hold);
            else         rd({3'b000, idx, 2'b00}, hold);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #3_000_000;
        errors++;
        $display("FAIL watchdog got no finish expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
